// File: rtl/pe_array_stream.sv
// R x C signed systolic MAC array with internal operand skew, a valid/ready beat input,
// and a row-serial shifted/saturated drain stream.
module pe_array_stream #(
  parameter int unsigned R  = 16,
  parameter int unsigned C  = 12,
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 48,
  parameter int unsigned KW = 16,
  parameter int unsigned OW = 32,
  parameter int unsigned SW = 6
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [KW-1:0]          K,
  input  logic                   accumulate,
  input  logic [SW-1:0]          shift,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [R*DW-1:0]        a_vec,
  input  logic [C*DW-1:0]        b_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [C*OW-1:0]        out_row,
  output logic [$clog2(R)-1:0]   out_row_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   sat_flag
);

  localparam int unsigned RIW = $clog2(R);
  localparam int unsigned FW  = $clog2(R + C);
  localparam logic [FW-1:0]  FlushLast = FW'(R + C - 1);
  localparam logic [RIW-1:0] RowLast   = RIW'(R - 1);
  localparam logic signed [AW-1:0] OutMax = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] OutMin = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} state_e;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, beat_q;
  logic [SW-1:0]  shift_q;
  logic [FW-1:0]  flush_q;
  logic [RIW-1:0] row_q;
  logic           sat_q, done_q;

  logic start_acc, in_fire, out_fire, sat_row;

  // Edge register: one captured beat (or bubble) per cycle.
  logic signed [DW-1:0] a_edge_q [R];
  logic signed [DW-1:0] b_edge_q [C];
  logic                 ev_q;

  logic signed [DW-1:0] a_skew [R];
  logic                 av_skew [R];
  logic signed [DW-1:0] b_skew [C];
  logic                 bv_skew [C];

  logic signed [DW-1:0] a_pe_q  [R][C-1];
  logic                 av_pe_q [R][C-1];
  logic signed [DW-1:0] b_pe_q  [R-1][C];
  logic                 bv_pe_q [R-1][C];

  logic signed [DW-1:0] a_in  [R][C];
  logic                 av_in [R][C];
  logic signed [DW-1:0] b_in  [R][C];
  logic                 bv_in [R][C];
  logic signed [AW-1:0] prod  [R][C];
  logic signed [AW-1:0] acc_q [R][C];

  logic signed [AW-1:0] drain_sh  [C];
  logic signed [AW-1:0] drain_val [C];

  // Done cycle is still IDLE but must not accept a new tile.
  assign start_acc   = (state_q == StIdle) && start && !done_q;
  assign in_ready    = (state_q == StLoad);
  assign out_valid   = (state_q == StDrain);
  assign busy        = (state_q != StIdle);
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign out_row_idx = row_q;
  assign out_last    = out_valid && (row_q == RowLast);
  assign done        = done_q;
  assign sat_flag    = sat_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_acc) state_d = (K != '0) ? StLoad : StDrain;
      StLoad:  if (in_fire && (beat_q == k_q - KW'(1))) state_d = StFlush;
      StFlush: if (flush_q == FlushLast) state_d = StDrain;
      StDrain: if (out_fire && out_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      k_q     <= '0;
      beat_q  <= '0;
      shift_q <= '0;
      flush_q <= '0;
      row_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= out_fire && out_last;
      flush_q <= (state_q == StFlush) ? flush_q + FW'(1) : '0;
      if (start_acc) begin
        k_q     <= K;
        shift_q <= shift;
        beat_q  <= '0;
        sat_q   <= 1'b0;
      end else if (in_fire) begin
        beat_q <= beat_q + KW'(1);
      end
      if (out_fire) begin
        row_q <= out_last ? '0 : row_q + RIW'(1);
        if (sat_row) sat_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ev_q <= 1'b0;
      for (int r = 0; r < R; r++) a_edge_q[r] <= '0;
      for (int c = 0; c < C; c++) b_edge_q[c] <= '0;
    end else begin
      ev_q <= in_fire;
      for (int r = 0; r < R; r++) a_edge_q[r] <= a_vec[r*DW +: DW];
      for (int c = 0; c < C; c++) b_edge_q[c] <= b_vec[c*DW +: DW];
    end
  end

  // Row r of A is delayed r cycles, column c of B is delayed c cycles.
  for (genvar r = 0; r < R; r++) begin : g_a_skew
    if (r == 0) begin : g_direct
      assign a_skew[r]  = a_edge_q[r];
      assign av_skew[r] = ev_q;
    end else begin : g_delay
      logic signed [DW-1:0] d_q [r];
      logic                 v_q [r];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < r; i++) begin
            d_q[i] <= '0;
            v_q[i] <= 1'b0;
          end
        end else begin
          d_q[0] <= a_edge_q[r];
          v_q[0] <= ev_q;
          for (int i = 1; i < r; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign a_skew[r]  = d_q[r-1];
      assign av_skew[r] = v_q[r-1];
    end
  end

  for (genvar c = 0; c < C; c++) begin : g_b_skew
    if (c == 0) begin : g_direct
      assign b_skew[c]  = b_edge_q[c];
      assign bv_skew[c] = ev_q;
    end else begin : g_delay
      logic signed [DW-1:0] d_q [c];
      logic                 v_q [c];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < c; i++) begin
            d_q[i] <= '0;
            v_q[i] <= 1'b0;
          end
        end else begin
          d_q[0] <= b_edge_q[c];
          v_q[0] <= ev_q;
          for (int i = 1; i < c; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign b_skew[c]  = d_q[c-1];
      assign bv_skew[c] = v_q[c-1];
    end
  end

  always_comb begin
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        a_in[r][c]  = (c == 0) ? a_skew[r]  : a_pe_q[r][(c == 0) ? 0 : c-1];
        av_in[r][c] = (c == 0) ? av_skew[r] : av_pe_q[r][(c == 0) ? 0 : c-1];
        b_in[r][c]  = (r == 0) ? b_skew[c]  : b_pe_q[(r == 0) ? 0 : r-1][c];
        bv_in[r][c] = (r == 0) ? bv_skew[c] : bv_pe_q[(r == 0) ? 0 : r-1][c];
        prod[r][c]  = $signed({{(AW-DW){a_in[r][c][DW-1]}}, a_in[r][c]}) *
                      $signed({{(AW-DW){b_in[r][c][DW-1]}}, b_in[r][c]});
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C - 1; c++) begin
          a_pe_q[r][c]  <= '0;
          av_pe_q[r][c] <= 1'b0;
        end
      end
      for (int r = 0; r < R - 1; r++) begin
        for (int c = 0; c < C; c++) begin
          b_pe_q[r][c]  <= '0;
          bv_pe_q[r][c] <= 1'b0;
        end
      end
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C; c++) acc_q[r][c] <= '0;
      end
    end else begin
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C - 1; c++) begin
          a_pe_q[r][c]  <= a_in[r][c];
          av_pe_q[r][c] <= av_in[r][c];
        end
      end
      for (int r = 0; r < R - 1; r++) begin
        for (int c = 0; c < C; c++) begin
          b_pe_q[r][c]  <= b_in[r][c];
          bv_pe_q[r][c] <= bv_in[r][c];
        end
      end
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C; c++) begin
          if (start_acc && !accumulate) begin
            acc_q[r][c] <= '0;
          end else if (av_in[r][c] && bv_in[r][c]) begin
            acc_q[r][c] <= acc_q[r][c] + prod[r][c];
          end
        end
      end
    end
  end

  always_comb begin
    out_row = '0;
    sat_row = 1'b0;
    for (int c = 0; c < C; c++) begin
      drain_sh[c]  = acc_q[row_q][c] >>> shift_q;
      drain_val[c] = drain_sh[c];
      if (drain_sh[c] > OutMax) begin
        drain_val[c] = OutMax;
        sat_row      = 1'b1;
      end else if (drain_sh[c] < OutMin) begin
        drain_val[c] = OutMin;
        sat_row      = 1'b1;
      end
      if (out_valid) out_row[c*OW +: OW] = drain_val[c][OW-1:0];
    end
  end

endmodule

// File: tb/tb_pe_array_stream.sv
// Scoreboard bench for pe_array_stream: a reference MAC model pushes expected drain rows
// at tile start; a negedge monitor pops and compares them on each handshake.
module tb_pe_array_stream;
  localparam int R = 4, C = 3, DW = 16, AW = 48, KW = 16, OW = 16, SW = 6;

  logic              clk = 1'b0;
  logic              rstn, start, accumulate, in_valid, out_ready;
  logic [KW-1:0]     K;
  logic [SW-1:0]     shift;
  logic [R*DW-1:0]   a_vec;
  logic [C*DW-1:0]   b_vec;
  logic              in_ready, out_valid, out_last, busy, done, sat_flag;
  logic [C*OW-1:0]   out_row;
  logic [1:0]        out_row_idx;

  pe_array_stream #(.R(R), .C(C), .DW(DW), .AW(AW), .KW(KW), .OW(OW), .SW(SW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .K(K), .accumulate(accumulate), .shift(shift),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last), .busy(busy), .done(done),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [C*OW-1:0] row;
    logic [1:0]      idx;
    logic            last;
  } exp_t;

  exp_t   sb_q[$];
  longint ref_acc [R][C];
  int     a_mem [8][R];
  int     b_mem [8][C];
  int     n_checks = 0, n_pass = 0;
  int     cyc = 0, last_hs_cyc = 0, stall_n = 0, stall_cnt = 0;
  bit     exp_sat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_row"}, out_row, 0);
    check_eq({tag, "_row_idx"}, out_row_idx, 0);
    check_eq({tag, "_out_last"}, out_last, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_sat"}, sat_flag, 0);
  endtask

  task automatic clear_model();
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) ref_acc[r][c] = 0;
    sb_q.delete();
  endtask

  task automatic fill(input int av, input int bv);
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < R; r++) a_mem[i][r] = av;
      for (int c = 0; c < C; c++) b_mem[i][c] = bv;
    end
  endtask

  task automatic fill_basic();
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < R; r++) a_mem[i][r] = r + 1;
      for (int c = 0; c < C; c++) b_mem[i][c] = c + 5;
    end
  endtask

  task automatic drive_beat(input int i);
    int t;
    for (int r = 0; r < R; r++) begin
      t = a_mem[i][r];
      a_vec[r*DW +: DW] = t[DW-1:0];
    end
    for (int c = 0; c < C; c++) begin
      t = b_mem[i][c];
      b_vec[c*DW +: DW] = t[DW-1:0];
    end
  endtask

  // Runs one tile; inj also fires stray starts in LOAD, DRAIN and on the done cycle.
  task automatic run_tile(input int k, input bit acc, input int sh, input bit bubbles,
                          input int stalls, input bit inj);
    int     i, budget;
    bit     tog, acc_now, got, inj_d;
    longint v;
    exp_t   e;
    stall_n = stalls;
    if (!acc) for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) ref_acc[r][c] = 0;
    for (int b = 0; b < k; b++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) ref_acc[r][c] += longint'(a_mem[b][r]) * b_mem[b][c];
    exp_sat = 0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        v = ref_acc[r][c] >>> sh;
        if (v > 32767) begin v = 32767; exp_sat = 1; end
        if (v < -32768) begin v = -32768; exp_sat = 1; end
        e.row[c*OW +: OW] = v[OW-1:0];
      end
      e.idx  = 2'(r);
      e.last = (r == R - 1);
      sb_q.push_back(e);
    end

    start = 1; K = KW'(k); accumulate = acc; shift = SW'(sh);
    @(posedge clk); #1;
    start = 0;
    i = 0; budget = 0; tog = 0;
    while (i < k && budget < 100) begin
      budget++;
      if (bubbles && tog) in_valid = 0;
      else begin
        in_valid = 1;
        drive_beat(i);
      end
      tog = !tog;
      if (inj && budget == 1) begin start = 1; K = 7; accumulate = 0; end
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      start = 0;
      if (acc_now) i++;
    end
    if (i < k) check_eq("load_timeout", 64'(i), 64'(k));
    in_valid = 0;

    got = 0; inj_d = 0;
    for (int n = 0; n < 500 && !got; n++) begin
      @(posedge clk); #1;
      start = 0;
      if (done) got = 1;
      else if (inj && !inj_d && out_valid) begin
        start = 1; K = 0; accumulate = 0; inj_d = 1;
      end
    end
    if (!got) check_eq("done_timeout", 0, 1);
    else begin
      check_eq("done_latency", 64'(cyc), 64'(last_hs_cyc));
      check_eq("sb_drained", 64'(sb_q.size()), 0);
      check_eq("sat_flag", sat_flag, exp_sat);
      check_eq("done_busy", busy, 0);
      if (inj) begin start = 1; K = 0; accumulate = 0; end
      @(posedge clk); #1;
      start = 0;
      check_eq("done_pulse", done, 0);
      check_eq("start_on_done_ignored", busy, 0);
    end
  endtask

  // Decides out_ready for the coming edge, then compares the presented row.
  initial begin
    exp_t e;
    out_ready = 1;
    forever begin
      @(negedge clk);
      if (!rstn || !out_valid) begin
        out_ready = 1;
        stall_cnt = 0;
      end else if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 1, 0);
      end else begin
        e = sb_q[0];
        check_eq("row", out_row, e.row);
        check_eq("row_idx", out_row_idx, e.idx);
        check_eq("out_last", out_last, e.last);
        if (stall_cnt < stall_n) begin
          out_ready = 0;
          stall_cnt++;
        end else begin
          out_ready = 1;
          stall_cnt = 0;
          void'(sb_q.pop_front());
          last_hs_cyc = cyc + 1;
        end
      end
    end
  end

  initial begin
    rstn = 0; start = 0; K = '0; accumulate = 0; shift = '0; in_valid = 0;
    a_vec = '0; b_vec = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rstn = 1;
    @(posedge clk); #1;

    fill_basic();
    run_tile(1, 0, 0, 0, 0, 0);

    fill(1, 2);
    run_tile(3, 0, 0, 1, 2, 0);

    fill_basic();
    run_tile(1, 0, 0, 0, 0, 0);
    run_tile(1, 1, 0, 0, 0, 0);
    run_tile(0, 0, 0, 0, 0, 0);

    fill(30000, 30000);
    run_tile(2, 0, 0, 0, 0, 0);
    fill(-30000, 30000);
    run_tile(2, 0, 0, 0, 1, 0);
    fill(30000, 30000);
    run_tile(2, 0, 16, 0, 0, 0);

    fill_basic();
    run_tile(2, 0, 0, 0, 1, 1);

    // Abort a tile mid-LOAD with reset.
    fill(9, 9);
    start = 1; K = 3; accumulate = 0; shift = '0;
    @(posedge clk); #1;
    start = 0;
    in_valid = 1;
    drive_beat(0);
    @(posedge clk); #1;
    rstn = 0;
    #1;
    check_idle_outputs("mid_load_reset");
    in_valid = 0;
    clear_model();
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk); #1;
    fill_basic();
    run_tile(1, 1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_array_stream.md
Name: pe_array_stream

Overview:
Next-generation R x C signed INT systolic MAC array. Adds an internal input-skew stage, a valid/ready input stream with bubble tolerance, and per-tile accumulate-or-clear mode. Drains results as a row-serial, shifted and saturated valid/ready output stream. Sits between the tile operand buffers and the requant/writeback path, so upstream logic no longer hand-skews operands or snapshots a wide accumulator bus.

Parameters:
R, 16, array rows (R >= 2)
C, 12, array columns (C >= 2)
DW, 16, signed operand width for A/B
AW, 48, signed accumulator width per PE
KW, 16, width of K (inner-dimension beat count)
OW, 32, signed drained output element width (OW <= AW)
SW, 6, width of shift control (arithmetic right shift amount, 0..AW-1)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle tile start; accepted only in IDLE
K  in  KW  beats in this tile; sampled on accepted start
accumulate  in  1  sampled on start: 1 = keep prior accumulators, 0 = clear
shift  in  SW  arithmetic right shift applied at drain; sampled on start
in_valid  in  1  input beat valid
in_ready  out  1  array accepts a beat
a_vec  in  R*DW  A(r,k) for all rows, unskewed, signed
b_vec  in  C*DW  B(k,c) for all cols, unskewed, signed
out_valid  out  1  drained row valid
out_ready  in  1  downstream accepts row
out_row  out  C*OW  sat(acc[r][c] >>> shift) for c = 0..C-1
out_row_idx  out  clog2(R)  row index r of out_row
out_last  out  1  high with row R-1
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after final drain handshake
sat_flag  out  1  sticky: some drained element clamped this tile; cleared on start

Behaviour:
- Reset (async, rstn=0): state IDLE; all accumulators, skew regs, and pipeline valids 0; in_ready, out_valid, out_last, busy, done, sat_flag = 0; out_row, out_row_idx = 0.
- Reset mid-tile aborts. No partial output; accumulators zeroed.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE: in_ready=0, out_valid=0. start=1 latches K, accumulate, shift; clears sat_flag. If accumulate=0, all accumulators are zeroed on the same edge.
  - Next state: LOAD if K != 0, else DRAIN (drains current contents).
- LOAD: in_ready=1.
  - Each in_valid&in_ready edge captures one beat.
  - Row r A-data is delayed r cycles before entering column 0; column c B-data is delayed c cycles before entering row 0. Valid travels with the data.
  - Cycles with in_valid=0 inject bubbles (valid=0). PEs MAC only when A-valid and B-valid are both high at the PE.
  - Array shifts every cycle and never stalls.
  - After the K-th accepted beat, go to FLUSH. in_ready drops the following cycle.
- FLUSH: fixed FLUSH_LAT = R+C cycles, counted by an internal counter. This covers skew (R-1)+(C-1), the edge register, and the PE register. Then DRAIN.
- DRAIN:
  - out_valid=1; out_row_idx starts at 0 and advances on each out_valid&out_ready.
  - out_row, out_row_idx, and out_last hold stable while out_valid=1 and out_ready=0.
  - On the handshake with row R-1 (out_last=1): go to IDLE, assert done for one cycle, drop out_valid.
- Arithmetic:
  - Products are DW x DW signed, sign-extended to AW.
  - Accumulation wraps modulo 2^AW (two's complement), no saturation.
  - Drain value = acc >>> shift (arithmetic, floor), then clamped to [-2^(OW-1), 2^(OW-1)-1].
  - Any clamp sets sat_flag, which holds until the next accepted start.
- Accumulators are not modified during DRAIN or IDLE, except by the start clear.
- start is ignored when state != IDLE, including the done cycle. A start arriving the cycle after done is accepted.
- Output throughput: one row per cycle when out_ready is held high. A tile takes K + R + C + R cycles minimum with no bubbles or backpressure.

Test Plan:
(Benches use R=4, C=3, DW=16, AW=48, OW=16.)
1. Basic: start, K=1, accumulate=0, shift=0; a=[1,2,3,4], b=[5,6,7] -> rows r=0..3 = (r+1)*[5,6,7], out_last on r=3, done 1 cycle later, sat_flag=0.
2. Bubbles + backpressure: K=3, all a=1, b=2, in_valid toggled 1/0; out_ready low 2 cycles per row -> every element 6; outputs stable while stalled; row order 0..3.
3. Accumulate: tile 1 as in scenario 1, then tile 2 same data with accumulate=1 -> rows 2*(r+1)*[5,6,7]. Tile 3 with accumulate=0, K=0 -> all rows 0.
4. Saturation/shift: K=2, all a=30000, b=30000 -> all 32767, sat_flag=1. Repeat with a=-30000 -> -32768. Repeat with shift=16, a=30000 -> 27465, sat_flag=0.
5. Control: start during LOAD/DRAIN is ignored. Assert rstn=0 mid-LOAD -> all outputs 0 immediately; the next tile (scenario 1 data, accumulate=1) yields the scenario 1 values.
